// File: rtl/vm_multi_ctrl_if.sv
// Front-end bundle of the vending controller: user coin/select/cancel, supplier
// slot writes, and the registered actuator/status outputs.
interface vm_multi_ctrl_if #(
    parameter int IW      = 3,
    parameter int CNT_W   = 4,
    parameter int PRICE_W = 8,
    parameter int BAL_W   = 16
);
    logic               coin_valid;
    logic [1:0]         coin_val;
    logic               sel_valid;
    logic [IW-1:0]      sel_idx;
    logic               cancel;
    logic               sup_valid;
    logic [IW-1:0]      sup_idx;
    logic [CNT_W-1:0]   sup_count;
    logic [PRICE_W-1:0] sup_price;
    logic               vend_valid;
    logic [IW-1:0]      vend_idx;
    logic               change_valid;
    logic [BAL_W-1:0]   change_amt;
    logic               coin_reject;
    logic [BAL_W-1:0]   balance;
    logic [2:0]         status;
    logic               busy;

    modport master (
        output coin_valid, coin_val, sel_valid, sel_idx, cancel,
               sup_valid, sup_idx, sup_count, sup_price,
        input  vend_valid, vend_idx, change_valid, change_amt,
               coin_reject, balance, status, busy
    );

    modport slave (
        input  coin_valid, coin_val, sel_valid, sel_idx, cancel,
               sup_valid, sup_idx, sup_count, sup_price,
        output vend_valid, vend_idx, change_valid, change_amt,
               coin_reject, balance, status, busy
    );
endinterface

// File: rtl/vm_multi_ctrl.sv
// Vending-machine controller: coin credit, per-slot inventory and price, vend,
// change return and cancel. Every output is a flop updated on the rising edge.
module vm_multi_ctrl #(
    parameter int N_ITEMS    = 8,
    parameter int CNT_W      = 4,
    parameter int PRICE_W    = 8,
    parameter int BAL_W      = 16,
    parameter int MAX_CREDIT = 1000
) (
    input logic            clk,
    input logic            hrst,
    vm_multi_ctrl_if.slave bus
);
    localparam int IW = $clog2(N_ITEMS);

    typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_e;
    typedef enum logic [2:0] {
        ST_OK           = 3'd0,
        ST_SOLD_OUT     = 3'd1,
        ST_INSUFFICIENT = 3'd2,
        ST_OVER_CREDIT  = 3'd3,
        ST_BAD_SEL      = 3'd4,
        ST_SUP_REJECT   = 3'd5
    } status_e;

    state_e             state_q, state_d;
    status_e            status_q, status_d;
    logic [BAL_W-1:0]   balance_q, balance_d;
    logic [CNT_W-1:0]   count_q [N_ITEMS];
    logic [CNT_W-1:0]   count_d [N_ITEMS];
    logic [PRICE_W-1:0] price_q [N_ITEMS];
    logic [PRICE_W-1:0] price_d [N_ITEMS];
    logic               vend_valid_q, vend_valid_d;
    logic [IW-1:0]      vend_idx_q, vend_idx_d;
    logic               change_valid_q, change_valid_d;
    logic [BAL_W-1:0]   change_amt_q, change_amt_d;
    logic               coin_reject_q, coin_reject_d;
    logic               busy_q, busy_d;

    logic [BAL_W-1:0]   coin_amt;
    logic [BAL_W:0]     coin_sum;
    logic               sel_in_range, sup_in_range;
    logic [IW-1:0]      sel_slot, sup_slot;
    logic [BAL_W-1:0]   sel_price;
    logic               user_any, user_status;

    always_comb begin
        case (bus.coin_val)
            2'b00:   coin_amt = BAL_W'(5);
            2'b01:   coin_amt = BAL_W'(10);
            2'b10:   coin_amt = BAL_W'(25);
            default: coin_amt = BAL_W'(100);
        endcase
    end

    // Out-of-range indices are steered to slot 0 so array reads stay in bounds;
    // the range flags gate every use of the slot.
    assign coin_sum     = {1'b0, balance_q} + {1'b0, coin_amt};
    assign sel_in_range = ({1'b0, bus.sel_idx} < (IW+1)'(N_ITEMS));
    assign sup_in_range = ({1'b0, bus.sup_idx} < (IW+1)'(N_ITEMS));
    assign sel_slot     = sel_in_range ? bus.sel_idx : '0;
    assign sup_slot     = sup_in_range ? bus.sup_idx : '0;
    assign sel_price    = BAL_W'(price_q[sel_slot]);
    assign user_any     = bus.coin_valid | bus.sel_valid | bus.cancel;

    always_comb begin
        state_d        = state_q;
        status_d       = status_q;
        balance_d      = balance_q;
        count_d        = count_q;
        price_d        = price_q;
        vend_valid_d   = 1'b0;
        vend_idx_d     = vend_idx_q;
        change_valid_d = 1'b0;
        change_amt_d   = change_amt_q;
        coin_reject_d  = 1'b0;
        user_status    = 1'b0;

        case (state_q)
            S_IDLE, S_CREDIT: begin
                if (bus.cancel) begin
                    coin_reject_d = bus.coin_valid;
                    if (state_q == S_CREDIT) begin
                        state_d        = S_CHANGE;
                        change_valid_d = 1'b1;
                        change_amt_d   = balance_q;
                        balance_d      = '0;
                        status_d       = ST_OK;
                        user_status    = 1'b1;
                    end
                end else if (bus.sel_valid) begin
                    coin_reject_d = bus.coin_valid;
                    user_status   = 1'b1;
                    if (!sel_in_range) begin
                        status_d = ST_BAD_SEL;
                    end else if (count_q[sel_slot] == '0) begin
                        status_d = ST_SOLD_OUT;
                    end else if (balance_q < sel_price) begin
                        status_d = ST_INSUFFICIENT;
                    end else begin
                        state_d           = S_VEND;
                        vend_valid_d      = 1'b1;
                        vend_idx_d        = sel_slot;
                        count_d[sel_slot] = count_q[sel_slot] - CNT_W'(1);
                        balance_d         = balance_q - sel_price;
                        status_d          = ST_OK;
                    end
                end else if (bus.coin_valid) begin
                    user_status = 1'b1;
                    if (coin_sum <= (BAL_W+1)'(MAX_CREDIT)) begin
                        balance_d = coin_sum[BAL_W-1:0];
                        state_d   = S_CREDIT;
                        status_d  = ST_OK;
                    end else begin
                        coin_reject_d = 1'b1;
                        status_d      = ST_OVER_CREDIT;
                    end
                end
            end
            S_VEND: begin
                coin_reject_d = bus.coin_valid;
                if (balance_q != '0) begin
                    state_d        = S_CHANGE;
                    change_valid_d = 1'b1;
                    change_amt_d   = balance_q;
                    balance_d      = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CHANGE: begin
                coin_reject_d = bus.coin_valid;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A dropped supplier write only reports when no user event claimed status.
        if (bus.sup_valid) begin
            if (state_q == S_IDLE && !user_any) begin
                if (sup_in_range) begin
                    count_d[sup_slot] = bus.sup_count;
                    price_d[sup_slot] = bus.sup_price;
                    status_d          = ST_OK;
                end else begin
                    status_d = ST_BAD_SEL;
                end
            end else if (!user_status) begin
                status_d = ST_SUP_REJECT;
            end
        end

        busy_d = (state_d == S_VEND) || (state_d == S_CHANGE);
    end

    always_ff @(posedge clk) begin
        if (hrst) begin
            state_q        <= S_IDLE;
            status_q       <= ST_OK;
            balance_q      <= '0;
            vend_valid_q   <= 1'b0;
            vend_idx_q     <= '0;
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;
            coin_reject_q  <= 1'b0;
            busy_q         <= 1'b0;
            // NOTE: the slot tables are functional state (reset must empty the
            // machine), so they are cleared here rather than left uninitialised.
            for (int i = 0; i < N_ITEMS; i++) begin
                count_q[i] <= '0;
                price_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            status_q       <= status_d;
            balance_q      <= balance_d;
            vend_valid_q   <= vend_valid_d;
            vend_idx_q     <= vend_idx_d;
            change_valid_q <= change_valid_d;
            change_amt_q   <= change_amt_d;
            coin_reject_q  <= coin_reject_d;
            busy_q         <= busy_d;
            count_q        <= count_d;
            price_q        <= price_d;
        end
    end

    assign bus.vend_valid   = vend_valid_q;
    assign bus.vend_idx     = vend_idx_q;
    assign bus.change_valid = change_valid_q;
    assign bus.change_amt   = change_amt_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.balance      = balance_q;
    assign bus.status       = status_q;
    assign bus.busy         = busy_q;
endmodule

// File: doc/vm_multi_ctrl.md
Name: vm_multi_ctrl

Overview:
- Parametrised next-generation vending-machine controller.
- Manages N_ITEMS product slots, each with an inventory count and a price, both loaded by the supplier.
- Accumulates coin credit, vends a selected item, returns change, and supports cancel.
- Sits between the user/supplier front-end and the dispense/change actuators. Replaces fixed-item, package-typed control with generic widths.

Parameters:
N_ITEMS, 8, number of product slots (2..64)
CNT_W, 4, width of per-slot inventory count
PRICE_W, 8, width of per-slot price (cents)
BAL_W, 16, width of credit/change values (cents)
MAX_CREDIT, 1000, highest credit accepted (cents)

Ports:
clk  in  1  clock, all logic on rising edge
hrst  in  1  synchronous active-high reset
coin_valid  in  1  one coin inserted this cycle
coin_val  in  2  00=5, 01=10, 10=25, 11=100 cents
sel_valid  in  1  selection request this cycle
sel_idx  in  IW=$clog2(N_ITEMS)  selected slot
cancel  in  1  abort transaction, return credit
sup_valid  in  1  supplier slot write this cycle
sup_idx  in  IW  slot being written
sup_count  in  CNT_W  new inventory count
sup_price  in  PRICE_W  new price
vend_valid  out  1  one-cycle dispense pulse
vend_idx  out  IW  slot dispensed
change_valid  out  1  one-cycle change pulse
change_amt  out  BAL_W  change value, valid with change_valid
coin_reject  out  1  one-cycle pulse: coin returned uncredited
balance  out  BAL_W  current credit
status  out  3  result of last event, held until next event
busy  out  1  high in VEND/CHANGE

Behaviour:
- Reset:
  - state=IDLE; balance=0; all counts and prices 0.
  - vend_valid, change_valid, coin_reject, busy = 0; change_amt=0; vend_idx=0; status=0.
  - Reset mid-VEND/CHANGE aborts with no pulse.
  - Reset dominates all inputs.
- States: IDLE (balance==0), CREDIT (balance>0), VEND, CHANGE.
- Status codes:
  - 0 OK
  - 1 SOLD_OUT
  - 2 INSUFFICIENT
  - 3 OVER_CREDIT
  - 4 BAD_SEL
  - 5 SUP_REJECT
- All outputs are registered. Each event takes effect on the next edge.
- Input priority in IDLE/CREDIT within one cycle: cancel > sel_valid > coin_valid. A lower-priority coin in the same cycle is rejected (coin_reject=1).
- Coin accepted:
  - Condition: balance+value <= MAX_CREDIT.
  - Effect: balance += value next cycle; IDLE->CREDIT; status=OK.
  - Otherwise: coin_reject pulse, balance unchanged, status=OVER_CREDIT.
- Selection, evaluated in this order against registered state:
  - sel_idx >= N_ITEMS -> BAD_SEL.
  - count==0 -> SOLD_OUT.
  - balance < price -> INSUFFICIENT.
  - Any of these failures: state unchanged.
  - Success -> VEND.
- VEND (one cycle):
  - vend_valid=1; vend_idx=sel_idx.
  - count[idx] -= 1; balance -= price; status=OK.
  - Next: CHANGE if remaining balance > 0, else IDLE.
  - A price-0 item vends from IDLE.
- CHANGE (one cycle):
  - change_valid=1; change_amt=balance; balance=0.
  - Next: IDLE.
- Cancel:
  - In CREDIT: -> CHANGE with the full balance.
  - In IDLE: no effect.
- busy=1 in VEND and CHANGE. In those states:
  - sel/cancel are ignored.
  - coin_valid produces coin_reject.
- Supplier write:
  - Accepted only in IDLE and only if no user input is valid that cycle.
  - Effect next cycle: count[sup_idx]=sup_count, price[sup_idx]=sup_price, status=OK.
  - Otherwise (busy, CREDIT, or concurrent user input) the write is dropped and status=SUP_REJECT.
  - sup_idx >= N_ITEMS -> dropped, status=BAD_SEL.
- Arithmetic:
  - Price is zero-extended to BAL_W.
  - Count never underflows, because the SOLD_OUT check precedes the decrement.
  - balance never exceeds MAX_CREDIT.

Test Plan:
- Reset, then supply slot 3 with count=2, price=65. Insert 25,25,25 -> balance=75. Select 3 -> vend_valid with vend_idx=3 one cycle after the select; change_valid with change_amt=10 the following cycle; balance=0; count[3]=1.
- Slot 3 with count=1: vend once with exact 65 -> no change pulse, IDLE. Insert 100, select 3 -> status=SOLD_OUT, balance stays 100. Cancel -> change_amt=100.
- Price 65, insert 25+25, select -> INSUFFICIENT with balance=50. Then insert 25, select -> vend with change 10.
- Insert ten 100-cent coins -> balance=1000. Eleventh coin -> coin_reject=1, status=OVER_CREDIT, balance=1000.
- Same cycle cancel+sel+coin with balance=30 -> change_amt=30, coin_reject=1, no vend. sup_valid while balance=30 -> SUP_REJECT, slot unchanged. sel_idx=N_ITEMS -> BAD_SEL.
- Assert hrst during the VEND cycle -> the next cycle shows all outputs at reset values, balance=0, no change pulse, counts and prices cleared.
